adder_arbiter: RTL and testbench
================================

// Module: adder_arbiter
// PURPOSE
//  Shares one 32-bit ripple-carry adder (FA32 instance) between NUM_REQ requesters.
//  Each requester issues (a,b) with a valid/ready handshake; the winner's sum is
//  registered into that requester's private response slot one cycle later.
//  Sits between the pipeline stages that each need an add (PC+4, branch target,
//  address calculation) and the single adder, replacing the per-stage adders.
// PARAMETERS
//  NUM_REQ  2  number of requesters; legal range 2..4
// PORTS
//  clk        in   1           rising-edge clock
//  rst_n      in   1           synchronous reset, active low
//  req_valid  in   NUM_REQ     requester i presents an operand pair
//  req_ready  out  NUM_REQ     one-hot grant; operands of i consumed this cycle
//  req_a      in   NUM_REQ*32  operand a; requester i at bits [32*i+31:32*i]
//  req_b      in   NUM_REQ*32  operand b; same packing as req_a
//  rsp_valid  out  NUM_REQ     response slot i holds a sum
//  rsp_ready  in   NUM_REQ     requester i accepts its sum this cycle
//  rsp_sum    out  NUM_REQ*32  registered sum per slot; same packing as req_a
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): rsp_valid=0, rsp_sum=0, rr_ptr=0. req_ready is
//    combinational and forced to 0 while rst_n=0. In-flight responses are dropped.
//  - eligible[i] = req_valid[i] & (~rsp_valid[i] | rsp_ready[i]). The slot must be
//    empty or draining this cycle, so back-to-back adds per requester are allowed.
//  - Arbitration is round-robin. Scan eligible from rr_ptr upward, wrapping modulo
//    NUM_REQ. The first eligible index g is granted: req_ready[g]=1, all others 0.
//    At most one grant per cycle. No eligible requester means no grant.
//  - On a grant, rr_ptr <= (g+1) mod NUM_REQ. Without a grant, rr_ptr holds.
//  - The adder inputs are muxed from requester g. On the next edge, rsp_sum[g] <= a+b
//    mod 2^32 (carry-out discarded) and rsp_valid[g] <= 1.
//  - Latency: grant in cycle N gives rsp_valid in cycle N+1. Throughput is 1 add/cycle
//    total.
//  - Slot i with rsp_ready[i]=1 and no new grant to i: rsp_valid[i] <= 0 and
//    rsp_sum[i] holds its last value. A simultaneous drain and grant leaves
//    rsp_valid[i] at 1 with the new sum.
//  - A full slot (rsp_valid=1, rsp_ready=0) makes its requester ineligible. The
//    other requesters proceed unaffected, so there is no head-of-line blocking.
//  - Requesters hold req_a/req_b/req_valid stable until req_ready. The arbiter
//    never retracts a grant within a cycle.
//  - req_ready depends combinationally on req_valid and rsp_ready. It does not
//    depend on req_a or req_b.
// CONFIGURATION
//  ADDER_ARB_PRIO0_EN defined: requester 0 wins whenever eligible[0]=1 and rr_ptr
//    is not updated on those grants. The others are round-robin among themselves
//    when requester 0 is not eligible.
//  Not defined: pure round-robin across all NUM_REQ, as described above.
// TESTING
//  1 Reset: hold rst_n=0 3 cycles with all req_valid=1 -> req_ready=0, rsp_valid=0,
//    rsp_sum=0 throughout.
//  2 Single add: req0 a=32'h0000_0005 b=32'h0000_0003 -> req_ready=2'b01 in cycle N;
//    rsp_valid[0]=1, rsp_sum[0]=32'h0000_0008 in cycle N+1.
//  3 Wrap: a=32'hFFFF_FFFF b=32'h0000_0002 -> rsp_sum=32'h0000_0001, no other flag.
//  4 Fairness: NUM_REQ=2, both valid every cycle, rsp_ready=2'b11 -> grants
//    alternate 01,10,01,10 from reset. With ADDER_ARB_PRIO0_EN: grants stay 01.
//  5 Backpressure: rsp_ready[1]=0 with slot 1 full, both requesting -> req0 granted
//    every cycle, req1 never. Raise rsp_ready[1] -> req1 granted within 2 cycles
//    (RR build).
//  6 Reset mid-op: assert rst_n=0 the cycle after a grant -> rsp_valid=0 next edge.
//    The dropped sum never appears. rr_ptr=0, so the first grant after release goes
//    to 0.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one ripple-carry adder between NUM_REQ requesters.
// Define ADDER_ARB_PRIO0_EN to give requester 0 fixed priority over the round-robin group.

module fa32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum
);
    logic [31:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ carry[i];
        if (i < 31) begin : g_carry
            assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end
endmodule

module adder_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_a,
    input  logic [NUM_REQ*32-1:0]   req_b,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [NUM_REQ*32-1:0]   rsp_sum
);
    localparam int PW = (NUM_REQ > 2) ? 2 : 1;

    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      rr_next;
    logic               rr_advance;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant_vec;
    logic               grant_any;
    logic [PW-1:0]      grant_idx;
    logic [PW:0]        scan_wide;
    logic [PW-1:0]      scan_idx;
    logic [31:0]        add_a;
    logic [31:0]        add_b;
    logic [31:0]        add_sum;

    // A slot that is draining this cycle can accept a new sum, allowing back-to-back adds.
    assign eligible = req_valid & (~rsp_valid | rsp_ready);

    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        scan_wide = '0;
        scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_wide = {1'b0, rr_ptr} + (PW+1)'(k);
            if (scan_wide >= (PW+1)'(NUM_REQ)) begin
                scan_wide = scan_wide - (PW+1)'(NUM_REQ);
            end
            scan_idx = scan_wide[PW-1:0];
            if (!grant_any && eligible[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
`ifdef ADDER_ARB_PRIO0_EN
        if (eligible[0]) begin
            grant_any = 1'b1;
            grant_idx = '0;
        end
`endif
    end

    always_comb begin
        grant_vec = '0;
        if (grant_any && rst_n) begin
            grant_vec[grant_idx] = 1'b1;
        end
    end

    assign req_ready = grant_vec;

    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == PW'(i)) begin
                add_a = req_a[32*i +: 32];
                add_b = req_b[32*i +: 32];
            end
        end
    end

    fa32 u_fa32 (
        .a   (add_a),
        .b   (add_b),
        .cin (1'b0),
        .sum (add_sum)
    );

    always_comb begin
        if (grant_idx == PW'(NUM_REQ - 1)) begin
            rr_next = '0;
        end else begin
            rr_next = grant_idx + PW'(1);
        end
`ifdef ADDER_ARB_PRIO0_EN
        // Fixed-priority wins by requester 0 leave the round-robin pointer alone.
        rr_advance = grant_any && (grant_idx != '0);
`else
        rr_advance = grant_any;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr    <= '0;
            rsp_valid <= '0;
            rsp_sum   <= '0;
        end else begin
            if (rr_advance) begin
                rr_ptr <= rr_next;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_vec[i]) begin
                    rsp_valid[i]        <= 1'b1;
                    rsp_sum[32*i +: 32] <= add_sum;
                end else if (rsp_ready[i]) begin
                    rsp_valid[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter with NUM_REQ=2.
// Expectations follow ADDER_ARB_PRIO0_EN when that macro is defined.

module tb_adder_arbiter;
    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [63:0] rsp_sum;

    int checks;
    int failures;

    adder_arbiter #(.NUM_REQ(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic rst_v, input logic [1:0] valid_v,
                                  input logic [1:0] ready_v,
                                  input logic [31:0] a0, input logic [31:0] b0,
                                  input logic [31:0] a1, input logic [31:0] b1);
        rst_n     = rst_v;
        req_valid = valid_v;
        rsp_ready = ready_v;
        req_a     = {a1, a0};
        req_b     = {b1, b0};
        #1;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs,
                                input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [1:0] fair_exp [4];
    logic [1:0] fair_valid_exp;
    logic [31:0] fair_sum1_exp;
    logic [1:0] bp_release_exp;

    initial begin
        checks   = 0;
        failures = 0;
`ifdef ADDER_ARB_PRIO0_EN
        fair_exp       = '{2'b01, 2'b01, 2'b01, 2'b01};
        fair_valid_exp = 2'b01;
        fair_sum1_exp  = 32'h0;
        bp_release_exp = 2'b01;
`else
        fair_exp       = '{2'b01, 2'b10, 2'b01, 2'b10};
        fair_valid_exp = 2'b10;
        fair_sum1_exp  = 32'd22;
        bp_release_exp = 2'b10;
`endif

        // Reset held three cycles with everyone requesting.
        apply_stimulus(1'b0, 2'b11, 2'b00, 32'd1, 32'd2, 32'd3, 32'd4);
        for (int c = 0; c < 3; c++) begin
            step();
            check_output("reset_ready", 64'(req_ready), 64'h0);
            check_output("reset_rsp_valid", 64'(rsp_valid), 64'h0);
            check_output("reset_rsp_sum", rsp_sum, 64'h0);
        end

        apply_stimulus(1'b1, 2'b00, 2'b00, 32'd0, 32'd0, 32'd0, 32'd0);
        check_output("idle_ready", 64'(req_ready), 64'h0);
        step();

        // Single add from requester 0.
        apply_stimulus(1'b1, 2'b01, 2'b00, 32'h5, 32'h3, 32'd0, 32'd0);
        check_output("single_ready", 64'(req_ready), 64'h1);
        step();
        check_output("single_rsp_valid", 64'(rsp_valid), 64'h1);
        check_output("single_sum0", 64'(rsp_sum[31:0]), 64'h8);

        // Wrap-around add into a draining slot.
        apply_stimulus(1'b1, 2'b01, 2'b01, 32'hFFFF_FFFF, 32'h2, 32'd0, 32'd0);
        check_output("wrap_ready", 64'(req_ready), 64'h1);
        step();
        check_output("wrap_rsp_valid", 64'(rsp_valid), 64'h1);
        check_output("wrap_sum0", 64'(rsp_sum[31:0]), 64'h1);

        // Drain clears valid but keeps the last sum.
        apply_stimulus(1'b1, 2'b00, 2'b11, 32'd0, 32'd0, 32'd0, 32'd0);
        step();
        check_output("drain_rsp_valid", 64'(rsp_valid), 64'h0);
        check_output("drain_sum0_hold", 64'(rsp_sum[31:0]), 64'h1);

        // Fairness from a fresh reset.
        apply_stimulus(1'b0, 2'b00, 2'b11, 32'd0, 32'd0, 32'd0, 32'd0);
        step();
        apply_stimulus(1'b1, 2'b11, 2'b11, 32'd10, 32'd1, 32'd20, 32'd2);
        for (int c = 0; c < 4; c++) begin
            check_output($sformatf("fair_ready_%0d", c), 64'(req_ready), 64'(fair_exp[c]));
            step();
        end
        check_output("fair_rsp_valid", 64'(rsp_valid), 64'(fair_valid_exp));
        check_output("fair_sum0", 64'(rsp_sum[31:0]), 64'd11);
        check_output("fair_sum1", 64'(rsp_sum[63:32]), 64'(fair_sum1_exp));

        // Backpressure on slot 1 while both keep requesting.
        apply_stimulus(1'b1, 2'b11, 2'b01, 32'd10, 32'd1, 32'd20, 32'd2);
        for (int c = 0; c < 3; c++) begin
            check_output($sformatf("bp_ready_%0d", c), 64'(req_ready), 64'h1);
            step();
        end
        apply_stimulus(1'b1, 2'b11, 2'b11, 32'd10, 32'd1, 32'd20, 32'd2);
        check_output("bp_release_ready", 64'(req_ready), 64'(bp_release_exp));
        step();
        check_output("bp_release_rsp_valid", 64'(rsp_valid), 64'(bp_release_exp));

        // Reset the cycle after a grant drops everything and rewinds the pointer.
        apply_stimulus(1'b1, 2'b01, 2'b00, 32'd100, 32'd23, 32'd20, 32'd2);
        check_output("midop_grant", 64'(req_ready), 64'h1);
        step();
        apply_stimulus(1'b0, 2'b11, 2'b00, 32'd100, 32'd23, 32'd20, 32'd2);
        check_output("midop_reset_ready", 64'(req_ready), 64'h0);
        step();
        check_output("midop_rsp_valid", 64'(rsp_valid), 64'h0);
        check_output("midop_rsp_sum", rsp_sum, 64'h0);
        apply_stimulus(1'b1, 2'b11, 2'b11, 32'd100, 32'd23, 32'd20, 32'd2);
        check_output("post_reset_ready", 64'(req_ready), 64'h1);
        step();
        check_output("post_reset_rsp_valid", 64'(rsp_valid), 64'h1);
        check_output("post_reset_sum", rsp_sum, {32'd0, 32'd123});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
